// File: rtl/trackball_emu_if.sv
// Signal bundle between the frame/input source (master) and the trackball emulator (slave).
interface trackball_emu_if;
    logic              strobe;
    logic              hold;
    logic signed [7:0] analog_x;
    logic signed [7:0] analog_y;
    logic              dig_left;
    logic              dig_right;
    logic              dig_up;
    logic              dig_down;
    logic [7:0]        pos_x;
    logic [7:0]        pos_y;
    logic              moving;

    modport master (
        output strobe, hold, analog_x, analog_y, dig_left, dig_right, dig_up, dig_down,
        input  pos_x, pos_y, moving
    );

    modport slave (
        input  strobe, hold, analog_x, analog_y, dig_left, dig_right, dig_up, dig_down,
        output pos_x, pos_y, moving
    );
endinterface

// File: rtl/trackball_emu.sv
// Trackball counter emulation: analog stick / digital keys -> two 8-bit position counters, once per frame.
// Optional macro TRACKBALL_CLAMP_EN: saturating positions (0..255) with reset value 8'h80.
module trackball_emu #(
    parameter int DEADZONE     = 8,
    parameter int SHIFT        = 3,
    parameter int DIG_MAX_STEP = 8,
    parameter int ACCEL_FRAMES = 4
) (
    input logic            clk,
    input logic            reset_n,
    trackball_emu_if.slave bus
);
    localparam int HC_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES + 1) : 1;
    localparam logic signed [8:0] DZ       = 9'(DEADZONE);
    localparam logic [6:0]        MAX_STEP = 7'(DIG_MAX_STEP);
    localparam logic [HC_W-1:0]   HC_LAST  = HC_W'(ACCEL_FRAMES - 1);
`ifdef TRACKBALL_CLAMP_EN
    localparam logic [7:0] POS_RST = 8'h80;
`else
    localparam logic [7:0] POS_RST = 8'h00;
`endif

    typedef struct packed {
        logic signed [8:0] delta;
        logic [6:0]        step;
        logic [HC_W-1:0]   hcnt;
    } axis_t;

    // One axis, one frame: analog overrides digital when outside the deadzone.
    function automatic axis_t axis_update(input logic signed [8:0] a,
                                          input logic              plus,
                                          input logic              minus,
                                          input logic [6:0]        step,
                                          input logic [HC_W-1:0]   hcnt);
        axis_t             r;
        logic signed [8:0] mag;
        logic signed [8:0] shifted;
        r.delta = '0;
        r.step  = 7'd1;
        r.hcnt  = hcnt;
        mag     = a[8] ? -a : a;
        shifted = a >>> SHIFT;
        if (mag > DZ) begin
            if (shifted == '0)
                r.delta = a[8] ? -9'sd1 : 9'sd1;
            else
                r.delta = shifted;
        end else if (plus ^ minus) begin
            r.delta = plus ? $signed({2'b00, step}) : -$signed({2'b00, step});
            if (hcnt == HC_LAST) begin
                r.hcnt = '0;
                r.step = (step >= MAX_STEP) ? MAX_STEP : step + 7'd1;
            end else begin
                r.hcnt = hcnt + 1'b1;
                r.step = step;
            end
        end else begin
            r.hcnt = '0;
        end
        return r;
    endfunction

    function automatic logic [7:0] pos_next(input logic [7:0] pos, input logic signed [8:0] delta);
`ifdef TRACKBALL_CLAMP_EN
        logic signed [9:0] sum;
        sum = $signed({2'b00, pos}) + $signed({delta[8], delta});
        if (sum < 10'sd0)
            return 8'h00;
        else if (sum > 10'sd255)
            return 8'hFF;
        else
            return sum[7:0];
`else
        return pos + delta[7:0];
`endif
    endfunction

    logic              strobe_q, strobe_d;
    logic [7:0]        pos_x_q, pos_x_d;
    logic [7:0]        pos_y_q, pos_y_d;
    logic              moving_q, moving_d;
    logic [6:0]        step_x_q, step_x_d;
    logic [6:0]        step_y_q, step_y_d;
    logic [HC_W-1:0]   hcnt_x_q, hcnt_x_d;
    logic [HC_W-1:0]   hcnt_y_q, hcnt_y_d;
    logic              rise;
    logic signed [8:0] a_x;
    logic signed [8:0] a_y;
    axis_t             upd_x;
    axis_t             upd_y;

    // Y is negated so that stick-up counts upward; 9 bits keep -(-128) exact.
    assign a_x  = {bus.analog_x[7], bus.analog_x};
    assign a_y  = -{bus.analog_y[7], bus.analog_y};
    assign rise = bus.strobe & ~strobe_q & ~bus.hold;

    always_comb begin
        strobe_d = bus.strobe;
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        moving_d = moving_q;
        step_x_d = step_x_q;
        step_y_d = step_y_q;
        hcnt_x_d = hcnt_x_q;
        hcnt_y_d = hcnt_y_q;
        upd_x    = axis_update(a_x, bus.dig_right, bus.dig_left, step_x_q, hcnt_x_q);
        upd_y    = axis_update(a_y, bus.dig_up, bus.dig_down, step_y_q, hcnt_y_q);
        if (rise) begin
            pos_x_d  = pos_next(pos_x_q, upd_x.delta);
            pos_y_d  = pos_next(pos_y_q, upd_y.delta);
            moving_d = (upd_x.delta != '0) | (upd_y.delta != '0);
            step_x_d = upd_x.step;
            step_y_d = upd_y.step;
            hcnt_x_d = upd_x.hcnt;
            hcnt_y_d = upd_y.hcnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strobe_q <= 1'b0;
            pos_x_q  <= POS_RST;
            pos_y_q  <= POS_RST;
            moving_q <= 1'b0;
            step_x_q <= 7'd1;
            step_y_q <= 7'd1;
            hcnt_x_q <= '0;
            hcnt_y_q <= '0;
        end else begin
            strobe_q <= strobe_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            moving_q <= moving_d;
            step_x_q <= step_x_d;
            step_y_q <= step_y_d;
            hcnt_x_q <= hcnt_x_d;
            hcnt_y_q <= hcnt_y_d;
        end
    end

    assign bus.pos_x  = pos_x_q;
    assign bus.pos_y  = pos_y_q;
    assign bus.moving = moving_q;
endmodule
